// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helper for the synchronous FIFO slice.
// Optional feature macro: SYNC_FIFO_ERR_FLAG_EN (sticky overflow/underflow flags).
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DATA_DEPTH = 16;
    localparam int DEF_AEMPTY_TH  = 2;

    // Ceiling log2, used for pointer width (count width is this plus one).
    function automatic int sf_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Bus interface of the synchronous FIFO: write/read requests, read data and status.
// Optional feature macro: SYNC_FIFO_ERR_FLAG_EN (drives overflow/underflow).
//
// Handshake: a write is taken on a rising clk when wr_en=1 and either fifo_full=0
// or a read is taken in the same cycle. A read is taken when rd_en=1 and
// fifo_empty=0; its word appears on data_out one clock later with rd_valid=1
// for exactly that cycle. Requests that are not taken are dropped, not held.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH
) ();

    localparam int CNT_W = sf_clog2(DATA_DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, rd_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, fifo_cnt, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, rd_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, fifo_cnt, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write port, registered read port.
// The read register holds its value when no read is enabled and clears on reset,
// so it can serve directly as the FIFO data output.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int ADDR_W     = sf_clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage write; contents are not reset (a reset only discards them logically).
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; reading the slot being written returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO control: pointers, occupancy count, registered status flags.
// Storage lives in sync_fifo_ram. Write-through-on-full: a full FIFO still takes
// a write when a read is taken in the same cycle.
// Optional feature macro: SYNC_FIFO_ERR_FLAG_EN (sticky overflow/underflow flags).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int AFULL_TH   = DATA_DEPTH - 2,
    parameter int AEMPTY_TH  = DEF_AEMPTY_TH
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);

    localparam int PTR_W = sf_clog2(DATA_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0] C_AFULL  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] C_AEMPTY = CNT_W'(AEMPTY_TH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_rd_valid;

    logic                  w_rd_accept;
    logic                  w_wr_accept;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_rd_accept = bus.rd_en && !r_empty;
    assign w_wr_accept = bus.wr_en && (!r_full || w_rd_accept);

    // Next occupancy: +1 write only, -1 read only, unchanged otherwise.
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_cnt_next = r_cnt + CNT_W'(1);
            2'b01:   w_cnt_next = r_cnt - CNT_W'(1);
            default: w_cnt_next = r_cnt;
        endcase
    end

    // Pointers advance on accepted accesses and wrap naturally at DATA_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd_accept) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Count and flags all load from the next-state count so they agree each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_next;
            r_full   <= (w_cnt_next == C_DEPTH);
            r_empty  <= (w_cnt_next == '0);
            r_afull  <= (w_cnt_next >= C_AFULL);
            r_aempty <= (w_cnt_next <= C_AEMPTY);
        end
    end

    // rd_valid marks the single cycle in which data_out carries a newly read word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign bus.data_out     = w_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.fifo_cnt     = r_cnt;
    assign bus.fifo_full    = r_full;
    assign bus.fifo_empty   = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;

`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: dropped write request, or read request while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && !w_wr_accept) r_overflow  <= 1'b1;
            if (bus.rd_en && r_empty)      r_underflow <= 1'b1;
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DATA_WIDTH=8, DATA_DEPTH=16, default thresholds).
// Error-flag expectations follow SYNC_FIFO_ERR_FLAG_EN as compiled.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int DD = 16;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sync_fifo_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) fifo_bus ();

    sync_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fifo_bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, "_cnt"},    32'(fifo_bus.fifo_cnt),     32'(cnt));
        chk({tag, "_full"},   32'(fifo_bus.fifo_full),    32'(cnt == 16));
        chk({tag, "_empty"},  32'(fifo_bus.fifo_empty),   32'(cnt == 0));
        chk({tag, "_afull"},  32'(fifo_bus.almost_full),  32'(cnt >= 14));
        chk({tag, "_aempty"}, 32'(fifo_bus.almost_empty), 32'(cnt <= 2));
    endtask

    task automatic chk_reset(input string tag);
        chk_flags(tag, 0);
        chk({tag, "_rd_valid"}, 32'(fifo_bus.rd_valid),  32'(0));
        chk({tag, "_data_out"}, 32'(fifo_bus.data_out),  32'(0));
        chk({tag, "_overflow"}, 32'(fifo_bus.overflow),  32'(0));
        chk({tag, "_underflow"}, 32'(fifo_bus.underflow), 32'(0));
    endtask

    // Driver: apply inputs just after an edge, sample 1 time unit after the next edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        fifo_bus.wr_en   = w;
        fifo_bus.data_in = d;
        fifo_bus.rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        fifo_bus.wr_en   = 1'b0;
        fifo_bus.rd_en   = 1'b0;
        fifo_bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 0x01..0x10
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, DW'(k), 1'b0);
            chk_flags($sformatf("fill%0d", k), k);
        end
        // 17th write is dropped
        step(1'b1, 8'hEE, 1'b0);
        chk_flags("wr17", 16);
        chk("wr17_overflow", 32'(fifo_bus.overflow), 32'(ERR_EN));
        chk("wr17_rd_valid", 32'(fifo_bus.rd_valid), 32'(0));

        // Drain: 0x01..0x10 in order, each with rd_valid
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 8'h00, 1'b1);
            chk($sformatf("drain%0d_data", k), 32'(fifo_bus.data_out), 32'(k));
            chk($sformatf("drain%0d_valid", k), 32'(fifo_bus.rd_valid), 32'(1));
            chk_flags($sformatf("drain%0d", k), 16 - k);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("idle_valid", 32'(fifo_bus.rd_valid), 32'(0));
        chk("idle_data_hold", 32'(fifo_bus.data_out), 32'h10);
        // Read while empty
        step(1'b0, 8'h00, 1'b1);
        chk("uf_valid", 32'(fifo_bus.rd_valid), 32'(0));
        chk("uf_data_hold", 32'(fifo_bus.data_out), 32'h10);
        chk("uf_underflow", 32'(fifo_bus.underflow), 32'(ERR_EN));
        chk_flags("uf", 0);

        // Full FIFO with simultaneous read/write: 0x21..0x30 then 0x31..0x35
        for (int k = 0; k < 16; k++) step(1'b1, DW'(8'h21 + k), 1'b0);
        chk_flags("refill", 16);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, DW'(8'h31 + k), 1'b1);
            chk($sformatf("wt%0d_data", k), 32'(fifo_bus.data_out), 32'(8'h21 + k));
            chk($sformatf("wt%0d_valid", k), 32'(fifo_bus.rd_valid), 32'(1));
            chk_flags($sformatf("wt%0d", k), 16);
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 8'h00, 1'b1);
            chk($sformatf("wtdrain%0d_data", k), 32'(fifo_bus.data_out), 32'(8'h26 + k));
        end
        chk_flags("wtdrain", 0);

        // Streaming at occupancy 3 for 40 words: pointers wrap more than twice
        for (int k = 0; k < 3; k++) step(1'b1, DW'(8'h40 + k), 1'b0);
        chk_flags("stream_pre", 3);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, DW'(8'h43 + k), 1'b1);
            chk($sformatf("stream%0d_data", k), 32'(fifo_bus.data_out), 32'(8'h40 + k));
            chk($sformatf("stream%0d_cnt", k), 32'(fifo_bus.fifo_cnt), 32'(3));
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b1);
            chk($sformatf("streamtail%0d_data", k), 32'(fifo_bus.data_out), 32'(8'h68 + k));
        end
        chk_flags("stream_post", 0);

        // Mid-burst asynchronous reset at occupancy 9
        for (int k = 0; k < 9; k++) step(1'b1, DW'(8'h80 + k), 1'b0);
        chk_flags("burst9", 9);
        fifo_bus.wr_en   = 1'b1;
        fifo_bus.data_in = 8'h99;
        #3 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        fifo_bus.wr_en = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("midrst_rel");
        step(1'b1, 8'hA5, 1'b0);
        chk_flags("postrst_wr", 1);
        step(1'b0, 8'h00, 1'b1);
        chk("postrst_rd_data", 32'(fifo_bus.data_out), 32'hA5);
        chk("postrst_rd_valid", 32'(fifo_bus.rd_valid), 32'(1));
        chk_flags("postrst_rd", 0);

        // Write into empty with read in the same cycle: no bypass
        step(1'b1, 8'h5A, 1'b1);
        chk_flags("nobypass", 1);
        chk("nobypass_valid", 32'(fifo_bus.rd_valid), 32'(0));
        chk("nobypass_data", 32'(fifo_bus.data_out), 32'hA5);
        chk("nobypass_underflow", 32'(fifo_bus.underflow), 32'(ERR_EN));
        step(1'b0, 8'h00, 1'b1);
        chk("nobypass_rd_data", 32'(fifo_bus.data_out), 32'h5A);
        chk("nobypass_rd_valid", 32'(fifo_bus.rd_valid), 32'(1));
        chk_flags("nobypass_rd", 0);
        step(1'b0, 8'h00, 1'b0);
        chk("final_valid", 32'(fifo_bus.rd_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (1..64).
REQ-002 SHALL have parameter DATA_DEPTH, default 16, entry count (power of 2, 4..1024).
REQ-003 SHALL have parameter AFULL_TH, default DATA_DEPTH-2, almost_full asserts when fifo_cnt >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost_empty asserts when fifo_cnt <= AEMPTY_TH.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports wr_en input 1 write request, and data_in input DATA_WIDTH write word.
REQ-008 SHALL have ports rd_en input 1 read request, and data_out output DATA_WIDTH read word (registered).
REQ-009 SHALL have port rd_valid  output  1  data_out updated this cycle by an accepted read.
REQ-010 SHALL have ports fifo_full and fifo_empty, both output 1, registered status.
REQ-011 SHALL have ports almost_full and almost_empty, both output 1, registered threshold flags.
REQ-012 SHALL have port fifo_cnt  output  $clog2(DATA_DEPTH)+1  current occupancy, 0..DATA_DEPTH.
REQ-013 SHALL have ports overflow and underflow, both output 1, sticky error flags.

Function
REQ-014 SHALL accept a read when rd_en=1 and fifo_empty=0; rd_en while empty is ignored.
REQ-015 SHALL accept a write when wr_en=1 and (fifo_full=0 or the read is accepted in the same cycle); this is write-through-on-full.
REQ-016 SHALL not bypass: a write accepted while empty is readable from the next cycle, not the same cycle.
REQ-017 SHALL load data_out with the head word one clock after rd_en is sampled, and pulse rd_valid high for exactly that cycle.
REQ-018 SHALL hold data_out unchanged when no read is accepted.
REQ-019 SHALL update fifo_cnt by +1 on write-only, -1 on read-only, and 0 on both or neither.
REQ-020 SHALL wrap read/write pointers modulo DATA_DEPTH with no lost or duplicated word.
REQ-021 SHALL compute fifo_full, fifo_empty, almost_full and almost_empty from the next-state count, so they are valid in the same cycle as fifo_cnt.
REQ-022 SHALL keep DATA_WIDTH-bit storage contents across wrap, and preserve FIFO order at all times.

Reset
REQ-023 SHALL on rst_n=0 immediately set pointers=0, fifo_cnt=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, rd_valid=0, data_out=0, overflow=0, underflow=0.
REQ-024 SHALL discard stored contents on a mid-operation reset; storage array need not be cleared.
REQ-025 SHALL release reset with the first accepted access on the first rising clk after rst_n=1.

Configuration
REQ-026 SHALL, with macro SYNC_FIFO_ERR_FLAG_EN defined, set overflow sticky on wr_en with no write accepted, and underflow sticky on rd_en while empty; both clear only on reset.
REQ-027 SHALL, without SYNC_FIFO_ERR_FLAG_EN, tie overflow and underflow to constant 0 and generate no error logic.

Structure
REQ-028 SHALL place a shared package sync_fifo_pkg holding the pointer/count width function (clog2) and default parameter constants.
REQ-029 SHALL instantiate one sub-module sync_fifo_ram: a DATA_DEPTH x DATA_WIDTH simple dual-port array, with a synchronous write port and a registered read port.
REQ-030 SHALL keep control (pointers, count, flags) in sync_fifo and storage only in sync_fifo_ram.

Verification (DATA_WIDTH=8, DATA_DEPTH=16, defaults)
REQ-031 SHALL cover: reset, then write 0x01..0x10 -> fifo_full=1 after the 16th write, almost_full=1 at cnt=14, then 17th write ignored (overflow=1 if ERR_FLAG_EN).
REQ-032 SHALL cover: drain all 16 -> data_out 0x01..0x10 in order, each with rd_valid one cycle after rd_en, fifo_empty=1 after the last read, then extra rd_en -> underflow=1 and data_out stays 0x10.
REQ-033 SHALL cover: full FIFO with wr_en=rd_en=1 for 5 cycles -> fifo_cnt stays 16, fifo_full stays 1, reads return the oldest 5 words.
REQ-034 SHALL cover: continuous simultaneous read/write for 40 words at cnt=3 -> pointers wrap twice, output order is exact, fifo_cnt is constant at 3.
REQ-035 SHALL cover: rst_n pulsed low at cnt=9 mid-burst -> all outputs at reset values asynchronously, and the next write/read returns the new data only.
REQ-036 SHALL cover: a write to an empty FIFO with rd_en=1 in the same cycle -> read ignored, fifo_cnt=1, and the word is read on the next cycle.
